cache_responder: RTL and testbench
==================================

CACHE_RESPONDER -- requirements
Module: cache_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning byte address width of the CPU bus.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning word width.
REQ-003 The block SHALL have parameter INDEX_BITS, default 4, meaning log2 of line count; each line holds one word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: CPU request present.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr, input, ADDR_WIDTH bits: byte address; bit 0 ignored, so words sit at even addresses.
REQ-009 The block SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data, valid while rsp_valid is high.
REQ-013 The block SHALL have port mem_cs, output, 1 bit: backing RAM request.
REQ-014 The block SHALL have port mem_we, output, 1 bit: backing RAM write.
REQ-015 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: backing RAM address, with bit 0 forced to 0.
REQ-016 The block SHALL have port mem_wdata, output, DATA_WIDTH bits: backing RAM write data.
REQ-017 The block SHALL have port mem_rdata, input, DATA_WIDTH bits: backing RAM read data, valid with mem_ack.
REQ-018 The block SHALL have port mem_ack, input, 1 bit: backing RAM completion, at least 1 cycle after mem_cs rises.

Function
REQ-019 Address decode SHALL be index = req_addr[INDEX_BITS:1] and tag = req_addr[ADDR_WIDTH-1:INDEX_BITS+1]; each line SHALL store a valid bit, a tag and a data word.
REQ-020 The FSM SHALL have four states: IDLE, FILL, WTHRU and RESP; req_ready SHALL be high only in IDLE.
REQ-021 IDLE handling on accept: read hit -> RESP; read miss -> FILL; any write -> WTHRU.
REQ-022 In FILL the block SHALL hold mem_cs=1, mem_we=0 and mem_addr=request address until mem_ack; on mem_ack it SHALL write the line (valid=1, tag, mem_rdata), latch rsp_rdata=mem_rdata and go to RESP.
REQ-023 In WTHRU the block SHALL hold mem_cs=1, mem_we=1, mem_addr and mem_wdata until mem_ack; on a tag hit it SHALL update the line data.
REQ-024 A write miss SHALL NOT allocate a line (write-through, no-write-allocate); on mem_ack the FSM SHALL go to RESP.
REQ-025 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-026 Read-hit latency SHALL be 1 cycle from accept to rsp_valid, with rsp_rdata taken from the line.
REQ-027 Miss and write latency SHALL be the mem_ack delay plus 1 cycle.
REQ-028 Request inputs SHALL be sampled only on accept; changes while req_ready is low SHALL be ignored.
REQ-029 mem_ack outside FILL or WTHRU SHALL be ignored; mem_cs SHALL be 0 in IDLE and RESP.
REQ-030 rsp_rdata SHALL hold its last value outside rsp_valid; during a write response it SHALL be the write data.
REQ-031 A read miss to an index holding another tag SHALL replace that line.
REQ-032 A read that follows a write hit SHALL return the written data.

Reset
REQ-033 While rst_n=0 the block SHALL force state=IDLE, clear all valid bits, and drive req_ready=1, rsp_valid=0, rsp_rdata=0, mem_cs=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-034 A reset asserted mid-FILL or mid-WTHRU SHALL abort the transfer with no line update and no rsp_valid; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-035 With macro CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count, each 16 bits and reset to 0, counting accepted read hits and read misses, saturating at 16'hFFFF; writes SHALL NOT be counted.
REQ-036 Without CACHE_STATS_EN, those ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-037 Scenario: cold read 0x11C, RAM returns 0x0001 after 3 cycles -> mem_cs held 3 cycles, rsp_valid 1 cycle later with 0x0001; repeated read -> rsp_valid 1 cycle after accept with no mem_cs.
REQ-038 Scenario: write 0x11E=0x0005 (miss), then read 0x11E -> write-through seen on mem; the read misses and fetches 0x0005.
REQ-039 Scenario: read 0x120 to fill, write 0x120=0x1234 (hit), read 0x120 -> 0x1234 with no mem_cs on the read.
REQ-040 Scenario: read 0x102, then read 0x122 (same index, new tag), then read 0x102 -> three misses, each with its own mem_cs.
REQ-041 Scenario: rst_n low during FILL, then mem_ack arrives -> no rsp_valid, mem_cs=0, and the next read of that address misses.
REQ-042 Scenario (CACHE_STATS_EN): after REQ-037 -> hit_count=1, miss_count=1; with counters forced to 0xFFFF, a further hit leaves hit_count at 0xFFFF.

Source files
------------

// File: rtl/cache_responder_if.sv
// CPU request/response and backing-RAM signal bundle for cache_responder.
interface cache_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_responder.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate cache.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module cache_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    cache_responder_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - 1 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, WTHRU, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [LINES-1:0]      valid_q, valid_d;

    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_data;

    logic [INDEX_BITS-1:0] req_idx, cur_idx;
    logic [TAG_W-1:0]      req_tag, cur_tag;
    logic                  req_hit, cur_hit;

    assign req_idx = bus.req_addr[INDEX_BITS:1];
    assign req_tag = bus.req_addr[ADDR_WIDTH-1:INDEX_BITS+1];
    assign cur_idx = addr_q[INDEX_BITS:1];
    assign cur_tag = addr_q[ADDR_WIDTH-1:INDEX_BITS+1];
    assign req_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign cur_hit = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_rdata = rdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        valid_d       = valid_q;
        line_we       = 1'b0;
        line_data     = wdata_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    // Word-align once here so mem_addr bit 0 is always 0.
                    addr_d  = bus.req_addr & ~{{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    wdata_d = bus.req_wdata;
                    if (bus.req_we) begin
                        state_d = WTHRU;
                    end else if (req_hit) begin
                        rdata_d = data_mem[req_idx];
                        state_d = RESP;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                bus.mem_cs = 1'b1;
                if (bus.mem_ack) begin
                    valid_d[cur_idx] = 1'b1;
                    line_we   = 1'b1;
                    line_data = bus.mem_rdata;
                    rdata_d   = bus.mem_rdata;
                    state_d   = RESP;
                end
            end
            WTHRU: begin
                bus.mem_cs = 1'b1;
                bus.mem_we = 1'b1;
                if (bus.mem_ack) begin
                    line_we = cur_hit;
                    rdata_d = wdata_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset: lines are gated by valid_q.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= line_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        rd_accept;

    assign rd_accept  = (state_q == IDLE) && bus.req_valid && !bus.req_we;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rd_accept && req_hit && hit_cnt_q != 16'hFFFF)
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (rd_accept && !req_hit && miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder with a delayed-ack backing RAM model.
module tb_cache_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_responder #(
        .ADDR_WIDTH(12), .DATA_WIDTH(16), .INDEX_BITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    logic [15:0] ram [0:2047];
    int  ack_delay = 3;
    bit  ack_en = 1'b1;
    int  ack_cnt = 0;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_en) begin
                if (bus.mem_cs && !bus.mem_ack) begin
                    ack_cnt++;
                    if (ack_cnt >= ack_delay) begin
                        bus.mem_ack = 1'b1;
                        if (bus.mem_we) begin
                            ram[bus.mem_addr[11:1]] = bus.mem_wdata;
                            bus.mem_rdata = 16'hDEAD;
                        end else begin
                            bus.mem_rdata = ram[bus.mem_addr[11:1]];
                        end
                        ack_cnt = 0;
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                    ack_cnt = 0;
                end
            end
        end
    end

    logic [15:0] rd, rd_after, mwd;
    logic [11:0] maddr;
    logic        mwe, rsp_after;
    int          lat, cs_cyc;

    task automatic do_req(input logic we, input logic [11:0] addr,
                          input logic [15:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        // Busy-time input changes must be ignored.
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = ~addr;
        bus.req_wdata = ~wd;
        lat = 0; cs_cyc = 0; maddr = '0; mwe = 1'b0; mwd = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.mem_cs) begin
                if (cs_cyc == 0) begin
                    maddr = bus.mem_addr; mwe = bus.mem_we; mwd = bus.mem_wdata;
                end
                cs_cyc++;
            end
            if (bus.rsp_valid) break;
        end
        rd = bus.rsp_rdata;
        @(negedge clk);
        rsp_after = bus.rsp_valid;
        rd_after  = bus.rsp_rdata;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.rsp_rdata); end
        if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL rst_mem_cs got %b want 0", bus.mem_cs); end
        if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
        if (bus.mem_addr !== 12'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_read();
        ack_delay = 3;
        do_req(1'b0, 12'h11C, 16'h0);
        checks += 6;
        if (cs_cyc !== 3) begin errors++; $display("FAIL cold_cs_cycles got %0d want 3", cs_cyc); end
        if (lat !== 4) begin errors++; $display("FAIL cold_latency got %0d want 4", lat); end
        if (rd !== 16'h0001) begin errors++; $display("FAIL cold_rdata got %h want 0001", rd); end
        if (maddr !== 12'h11C || mwe !== 1'b0) begin errors++; $display("FAIL cold_mem_addr got %h/%b want 11c/0", maddr, mwe); end
        if (rsp_after !== 1'b0) begin errors++; $display("FAIL cold_pulse got %b want 0", rsp_after); end
        if (rd_after !== 16'h0001) begin errors++; $display("FAIL cold_hold got %h want 0001", rd_after); end
        do_req(1'b0, 12'h11D, 16'h0);
        checks += 3;
        if (cs_cyc !== 0) begin errors++; $display("FAIL hit_cs_cycles got %0d want 0", cs_cyc); end
        if (lat !== 1) begin errors++; $display("FAIL hit_latency got %0d want 1", lat); end
        if (rd !== 16'h0001) begin errors++; $display("FAIL hit_rdata got %h want 0001", rd); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        checks += 2;
        if (hit_count !== 16'd1) begin errors++; $display("FAIL stats_hit got %0d want 1", hit_count); end
        if (miss_count !== 16'd1) begin errors++; $display("FAIL stats_miss got %0d want 1", miss_count); end
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        #1;
        release dut.hit_cnt_q;
        do_req(1'b0, 12'h11C, 16'h0);
        checks += 2;
        if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h want ffff", hit_count); end
        if (miss_count !== 16'd1) begin errors++; $display("FAIL stats_miss2 got %0d want 1", miss_count); end
    endtask
`endif

    task automatic test_write_miss();
        ack_delay = 2;
        do_req(1'b1, 12'h11E, 16'h0005);
        checks += 5;
        if (cs_cyc !== 2 || lat !== 3) begin errors++; $display("FAIL wmiss_timing got cs=%0d lat=%0d want 2/3", cs_cyc, lat); end
        if (maddr !== 12'h11E || mwe !== 1'b1) begin errors++; $display("FAIL wmiss_mem got %h/%b want 11e/1", maddr, mwe); end
        if (mwd !== 16'h0005) begin errors++; $display("FAIL wmiss_wdata got %h want 0005", mwd); end
        if (rd !== 16'h0005) begin errors++; $display("FAIL wmiss_rsp got %h want 0005", rd); end
        if (ram[12'h11E >> 1] !== 16'h0005) begin errors++; $display("FAIL wmiss_ram got %h want 0005", ram[12'h11E >> 1]); end
        do_req(1'b0, 12'h11E, 16'h0);
        checks += 2;
        if (cs_cyc !== 2) begin errors++; $display("FAIL wmiss_read_cs got %0d want 2", cs_cyc); end
        if (rd !== 16'h0005) begin errors++; $display("FAIL wmiss_read got %h want 0005", rd); end
    endtask

    task automatic test_write_hit();
        ack_delay = 1;
        do_req(1'b0, 12'h120, 16'h0);
        checks += 1;
        if (rd !== 16'h00C0) begin errors++; $display("FAIL whit_fill got %h want 00c0", rd); end
        do_req(1'b1, 12'h120, 16'h1234);
        checks += 1;
        if (cs_cyc !== 1 || lat !== 2) begin errors++; $display("FAIL whit_timing got cs=%0d lat=%0d want 1/2", cs_cyc, lat); end
        do_req(1'b0, 12'h120, 16'h0);
        checks += 2;
        if (cs_cyc !== 0 || lat !== 1) begin errors++; $display("FAIL whit_read_hit got cs=%0d lat=%0d want 0/1", cs_cyc, lat); end
        if (rd !== 16'h1234) begin errors++; $display("FAIL whit_read got %h want 1234", rd); end
    endtask

    task automatic test_conflict();
        ack_delay = 2;
        do_req(1'b0, 12'h102, 16'h0);
        checks += 1;
        if (cs_cyc !== 2 || rd !== 16'hA102) begin errors++; $display("FAIL conf_a got cs=%0d d=%h want 2/a102", cs_cyc, rd); end
        do_req(1'b0, 12'h122, 16'h0);
        checks += 1;
        if (cs_cyc !== 2 || rd !== 16'hB122) begin errors++; $display("FAIL conf_b got cs=%0d d=%h want 2/b122", cs_cyc, rd); end
        do_req(1'b0, 12'h102, 16'h0);
        checks += 1;
        if (cs_cyc !== 2 || rd !== 16'hA102) begin errors++; $display("FAIL conf_a2 got cs=%0d d=%h want 2/a102", cs_cyc, rd); end
    endtask

    task automatic test_reset_mid_fill();
        logic saw_rsp;
        ack_en = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h140;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks += 1;
        if (bus.mem_cs !== 1'b1) begin errors++; $display("FAIL mid_fill_cs got %b want 1", bus.mem_cs); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL mid_rst_cs got %b want 0", bus.mem_cs); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", bus.req_ready); end
        if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", bus.rsp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rdata = 16'h7777;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_cs) saw_rsp = 1'b1;
        end
        checks += 1;
        if (saw_rsp !== 1'b0) begin errors++; $display("FAIL late_ack_ignored got %b want 0", saw_rsp); end
        ack_cnt = 0;
        ack_en = 1'b1;
        ack_delay = 2;
        do_req(1'b0, 12'h140, 16'h0);
        checks += 2;
        if (cs_cyc !== 2 || lat !== 3) begin errors++; $display("FAIL post_rst_miss got cs=%0d lat=%0d want 2/3", cs_cyc, lat); end
        if (rd !== 16'h0A0A) begin errors++; $display("FAIL post_rst_data got %h want 0a0a", rd); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 16'h0;
        ram[12'h11C >> 1] = 16'h0001;
        ram[12'h120 >> 1] = 16'h00C0;
        ram[12'h102 >> 1] = 16'hA102;
        ram[12'h122 >> 1] = 16'hB122;
        ram[12'h140 >> 1] = 16'h0A0A;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_cold_read();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_write_miss();
        test_write_hit();
        test_conflict();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
